// File: rtl/cga_vram_arbiter_if.sv
// CGA VRAM arbiter bus bundle: video fetch, ISA CPU slot and RAM pins.
// slave = arbiter side, master = sequencer/CPU/RAM side.
interface cga_vram_arbiter_if;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic        isa_op_enable;
  logic        cpu_cs;
  logic        cpu_memr_l;
  logic        cpu_memw_l;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        bus_rdy;
  logic [18:0] ram_a;
  logic [7:0]  ram_d_in;
  logic [7:0]  ram_d_out;
  logic        ram_we_l;
  logic        vid_grant;

  modport slave (
    input  vid_req, vid_addr, isa_op_enable, cpu_cs,
    input  cpu_memr_l, cpu_memw_l, cpu_addr, cpu_wdata,
    input  ram_d_in,
    output cpu_rdata, bus_rdy, ram_a, ram_d_out,
    output ram_we_l, vid_grant
  );

  modport master (
    output vid_req, vid_addr, isa_op_enable, cpu_cs,
    output cpu_memr_l, cpu_memw_l, cpu_addr, cpu_wdata,
    output ram_d_in,
    input  cpu_rdata, bus_rdy, ram_a, ram_d_out,
    input  ram_we_l, vid_grant
  );
endinterface

// File: rtl/cga_vram_arbiter.sv
// CGA VRAM arbiter: video fetches always win, CPU accesses
// wait for a sequencer slot or are forced after MAX_WAIT cycles.
module cga_vram_arbiter #(
  parameter logic [3:0] RAM_BASE = 4'b0001,
  parameter logic [7:0] MAX_WAIT = 8'd40
) (
  input logic             clk,
  input logic             reset_l,
  cga_vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SLOT, ACC_ADDR, ACC_DATA, HOLD
  } state_t;

  state_t      state_q, state_d;
  logic        memr_q, memw_q;
  logic        live_q, arm_q, arm_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [14:0] addr_q, addr_d;
  logic        vid, cpu_req, in_acc, cnt_max;

  assign vid     = bus.vid_req & reset_l;
  assign in_acc  = (state_q == ACC_ADDR) |
                   (state_q == ACC_DATA);
  assign cnt_max = (cnt_q == MAX_WAIT);
  assign cpu_req = arm_q & bus.cpu_cs &
                   (~memr_q | ~memw_q);
  // Only a strobe seen high after reset may start an access.
  assign arm_d   = arm_q | (live_q & memr_q & memw_q);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      memr_q  <= 1'b1;
      memw_q  <= 1'b1;
      live_q  <= 1'b0;
      arm_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      addr_q  <= 15'd0;
    end else begin
      state_q <= state_d;
      memr_q  <= bus.cpu_memr_l;
      memw_q  <= bus.cpu_memw_l;
      live_q  <= 1'b1;
      arm_q   <= arm_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = WAIT_SLOT;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = ~memw_q;
        end
      end
      WAIT_SLOT: begin
        cnt_d = cnt_max ? cnt_q : cnt_q + 8'd1;
        if (!vid && (bus.isa_op_enable || cnt_max))
          state_d = ACC_ADDR;
      end
      ACC_ADDR: begin
        state_d = vid ? WAIT_SLOT : ACC_DATA;
      end
      ACC_DATA: begin
        // A stray video fetch here voids the data; retry.
        if (vid) begin
          state_d = WAIT_SLOT;
        end else begin
          state_d = HOLD;
          if (!we_q) rdata_d = bus.ram_d_in;
        end
      end
      HOLD: begin
        if (memr_q && memw_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_a     = {RAM_BASE,
                          (in_acc && !vid) ? addr_q
                                           : bus.vid_addr};
  assign bus.ram_we_l  = ~((state_q == ACC_ADDR) &
                           we_q & ~vid);
  assign bus.vid_grant = vid;
  assign bus.bus_rdy   = ~((state_q == WAIT_SLOT) | in_acc);
  assign bus.ram_d_out = wdata_q;
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter: write, read, contention,
// starvation, strobe corner cases, mid-access reset, back-to-back.
module tb_cga_vram_arbiter;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cga_vram_arbiter_if bus();

  cga_vram_arbiter #(
    .RAM_BASE(4'b0001),
    .MAX_WAIT(8'd40)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM: one-cycle read latency, distinct data at 0x7FFF
  always @(posedge clk)
    bus.ram_d_in <= (bus.ram_a == 19'h0FFFF) ? 8'h3C : 8'h5A;

  int          we_cnt, pulse_cnt, lo_cnt, cyc;
  int          first_we, last_we, rise_cnt;
  logic        prev_we, prev_rdy;
  logic [18:0] we_a, we_a0;
  logic [7:0]  we_d, we_d0, rd_pre, rd_rise;

  task clr();
    we_cnt = 0; pulse_cnt = 0; lo_cnt = 0; cyc = 0;
    first_we = -1; last_we = -1; rise_cnt = 0;
    prev_we = 1'b1; prev_rdy = 1'b1;
    we_a = '0; we_a0 = '0; we_d = '0; we_d0 = '0;
    rd_pre = '0; rd_rise = '0;
  endtask

  task step();
    @(negedge clk);
    if (!bus.ram_we_l) begin
      if (prev_we) begin
        pulse_cnt++;
        if (pulse_cnt == 1) begin
          we_a0 = bus.ram_a; we_d0 = bus.ram_d_out;
          first_we = cyc;
        end
      end
      we_cnt++; we_a = bus.ram_a; we_d = bus.ram_d_out;
      last_we = cyc;
    end
    prev_we = bus.ram_we_l;
    if (!bus.bus_rdy) begin
      lo_cnt++; rd_pre = bus.cpu_rdata;
    end else if (!prev_rdy) begin
      rise_cnt++; rd_rise = bus.cpu_rdata;
    end
    prev_rdy = bus.bus_rdy;
    cyc++;
    @(posedge clk); #1;
  endtask

  task steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task cpu(input logic r_l, input logic w_l,
           input logic [14:0] a, input logic [7:0] d);
    bus.cpu_cs = 1'b1; bus.cpu_memr_l = r_l;
    bus.cpu_memw_l = w_l; bus.cpu_addr = a;
    bus.cpu_wdata = d;
  endtask

  task test_reset();
    bus.vid_req = 1'b1; bus.vid_addr = 15'h1234;
    bus.isa_op_enable = 1'b1; bus.cpu_cs = 1'b0;
    bus.cpu_memr_l = 1'b1; bus.cpu_memw_l = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    #3;
    checks++;
    if (bus.bus_rdy !== 1'b1) begin failures++;
      $display("FAIL rst_rdy got=%b exp=1", bus.bus_rdy); end
    checks++;
    if (bus.ram_we_l !== 1'b1) begin failures++;
      $display("FAIL rst_we got=%b exp=1", bus.ram_we_l); end
    checks++;
    if (bus.vid_grant !== 1'b0) begin failures++;
      $display("FAIL rst_grant got=%b exp=0", bus.vid_grant); end
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin failures++;
      $display("FAIL rst_rdata got=%h exp=00", bus.cpu_rdata); end
    checks++;
    if (bus.ram_d_out !== 8'h00) begin failures++;
      $display("FAIL rst_dout got=%h exp=00", bus.ram_d_out); end
    checks++;
    if (bus.ram_a !== 19'h09234) begin failures++;
      $display("FAIL rst_addr got=%h exp=09234", bus.ram_a); end
    bus.vid_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_l = 1'b1;
    bus.vid_req = 1'b1; bus.vid_addr = 15'h0ABC;
    #1;
    checks++;
    if (bus.vid_grant !== 1'b1) begin failures++;
      $display("FAIL vid_grant got=%b exp=1", bus.vid_grant); end
    checks++;
    if (bus.ram_a !== 19'h08ABC) begin failures++;
      $display("FAIL vid_addr got=%h exp=08abc", bus.ram_a); end
    bus.vid_req = 1'b0;
    #1;
    checks++;
    if (bus.ram_a !== 19'h08ABC) begin failures++;
      $display("FAIL idle_addr got=%h exp=08abc", bus.ram_a); end
    steps(3);
  endtask

  task test_write();
    clr();
    cpu(1'b1, 1'b0, 15'h0123, 8'hA5);
    steps(8);
    bus.cpu_memw_l = 1'b1;
    steps(3);
    checks++;
    if (we_cnt !== 1) begin failures++;
      $display("FAIL wr_count got=%0d exp=1", we_cnt); end
    checks++;
    if (we_a !== 19'h08123) begin failures++;
      $display("FAIL wr_addr got=%h exp=08123", we_a); end
    checks++;
    if (we_d !== 8'hA5) begin failures++;
      $display("FAIL wr_data got=%h exp=a5", we_d); end
    checks++;
    if (lo_cnt !== 3) begin failures++;
      $display("FAIL wr_rdy_low got=%0d exp=3", lo_cnt); end
    checks++;
    if (first_we !== 3) begin failures++;
      $display("FAIL wr_cycle got=%0d exp=3", first_we); end
  endtask

  task test_read();
    clr();
    cpu(1'b0, 1'b1, 15'h7FFF, 8'h00);
    steps(8);
    bus.cpu_memr_l = 1'b1;
    steps(3);
    checks++;
    if (we_cnt !== 0) begin failures++;
      $display("FAIL rd_we got=%0d exp=0", we_cnt); end
    checks++;
    if (lo_cnt !== 3) begin failures++;
      $display("FAIL rd_rdy_low got=%0d exp=3", lo_cnt); end
    checks++;
    if (rd_pre !== 8'h00) begin failures++;
      $display("FAIL rd_early got=%h exp=00", rd_pre); end
    checks++;
    if (rd_rise !== 8'h3C) begin failures++;
      $display("FAIL rd_at_rise got=%h exp=3c", rd_rise); end
    checks++;
    if (bus.cpu_rdata !== 8'h3C) begin failures++;
      $display("FAIL rd_hold got=%h exp=3c", bus.cpu_rdata); end
  endtask

  task test_both_strobes();
    clr();
    cpu(1'b0, 1'b0, 15'h0055, 8'hC3);
    steps(8);
    bus.cpu_memr_l = 1'b1; bus.cpu_memw_l = 1'b1;
    steps(3);
    checks++;
    if (we_cnt !== 1) begin failures++;
      $display("FAIL both_we got=%0d exp=1", we_cnt); end
    checks++;
    if (we_a !== 19'h08055) begin failures++;
      $display("FAIL both_addr got=%h exp=08055", we_a); end
    checks++;
    if (bus.cpu_rdata !== 8'h3C) begin failures++;
      $display("FAIL both_rdata got=%h exp=3c", bus.cpu_rdata); end
  endtask

  task test_contention();
    clr();
    bus.vid_req = 1'b1; bus.vid_addr = 15'h1234;
    cpu(1'b1, 1'b0, 15'h0456, 8'h77);
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (bus.ram_a !== 19'h09234) begin failures++;
        $display("FAIL cont_addr[%0d] got=%h exp=09234",
                 i, bus.ram_a); end
      checks++;
      if (bus.vid_grant !== 1'b1) begin failures++;
        $display("FAIL cont_grant[%0d] got=%b exp=1",
                 i, bus.vid_grant); end
      step();
    end
    checks++;
    if (we_cnt !== 0) begin failures++;
      $display("FAIL cont_early_we got=%0d exp=0", we_cnt); end
    bus.vid_req = 1'b0;
    clr();
    steps(8);
    bus.cpu_memw_l = 1'b1;
    steps(3);
    checks++;
    if (first_we !== 1) begin failures++;
      $display("FAIL cont_start got=%0d exp=1", first_we); end
    checks++;
    if (we_cnt !== 1) begin failures++;
      $display("FAIL cont_we got=%0d exp=1", we_cnt); end
    checks++;
    if (we_a !== 19'h08456 || we_d !== 8'h77) begin
      failures++;
      $display("FAIL cont_wr got=%h/%h exp=08456/77",
               we_a, we_d); end
  endtask

  task test_starvation();
    clr();
    bus.isa_op_enable = 1'b0;
    cpu(1'b1, 1'b0, 15'h0200, 8'h11);
    steps(10);
    bus.cpu_memw_l = 1'b1;
    steps(50);
    bus.isa_op_enable = 1'b1;
    checks++;
    if (lo_cnt !== 43) begin failures++;
      $display("FAIL starve_rdy_low got=%0d exp=43", lo_cnt); end
    checks++;
    if (first_we !== 43) begin failures++;
      $display("FAIL starve_cycle got=%0d exp=43", first_we); end
    checks++;
    if (we_cnt !== 1 || we_a !== 19'h08200) begin
      failures++;
      $display("FAIL starve_wr got=%0d/%h exp=1/08200",
               we_cnt, we_a); end
    checks++;
    if (rise_cnt !== 1 || bus.bus_rdy !== 1'b1) begin
      failures++;
      $display("FAIL starve_exit got=%0d/%b exp=1/1",
               rise_cnt, bus.bus_rdy); end
  endtask

  task test_reset_mid();
    clr();
    cpu(1'b1, 1'b0, 15'h0333, 8'h99);
    steps(3);
    checks++;
    if (bus.ram_we_l !== 1'b0) begin failures++;
      $display("FAIL mid_pre_we got=%b exp=0", bus.ram_we_l); end
    reset_l = 1'b0;
    #1;
    checks++;
    if (bus.ram_we_l !== 1'b1) begin failures++;
      $display("FAIL mid_we got=%b exp=1", bus.ram_we_l); end
    checks++;
    if (bus.bus_rdy !== 1'b1) begin failures++;
      $display("FAIL mid_rdy got=%b exp=1", bus.bus_rdy); end
    clr();
    steps(2);
    reset_l = 1'b1;
    steps(6);
    checks++;
    if (we_cnt !== 0 || lo_cnt !== 0) begin failures++;
      $display("FAIL mid_no_access got=%0d/%0d exp=0/0",
               we_cnt, lo_cnt); end
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin failures++;
      $display("FAIL mid_rdata got=%h exp=00", bus.cpu_rdata); end
    bus.cpu_memw_l = 1'b1;
    steps(3);
  endtask

  task test_back_to_back();
    clr();
    cpu(1'b1, 1'b0, 15'h0010, 8'h01);
    steps(6);
    bus.cpu_memw_l = 1'b1;
    step();
    cpu(1'b1, 1'b0, 15'h0011, 8'h02);
    steps(8);
    bus.cpu_memw_l = 1'b1;
    steps(3);
    checks++;
    if (pulse_cnt !== 2 || we_cnt !== 2) begin failures++;
      $display("FAIL b2b_pulses got=%0d/%0d exp=2/2",
               pulse_cnt, we_cnt); end
    checks++;
    if (we_a0 !== 19'h08010 || we_d0 !== 8'h01) begin
      failures++;
      $display("FAIL b2b_first got=%h/%h exp=08010/01",
               we_a0, we_d0); end
    checks++;
    if (we_a !== 19'h08011 || we_d !== 8'h02) begin
      failures++;
      $display("FAIL b2b_second got=%h/%h exp=08011/02",
               we_a, we_d); end
    checks++;
    if (first_we !== 3 || last_we !== 10) begin failures++;
      $display("FAIL b2b_timing got=%0d/%0d exp=3/10",
               first_we, last_we); end
    checks++;
    if (lo_cnt !== 6) begin failures++;
      $display("FAIL b2b_rdy_low got=%0d exp=6", lo_cnt); end
  endtask

  initial begin
    clr();
    test_reset();
    test_write();
    test_read();
    test_both_strobes();
    test_contention();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
